// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg: state type, sync constants and stat helpers.
// Stat counters are built only with FRAME_SYNC_STATS_EN defined.
package frame_sync_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } state_e;

  localparam int SYNC_LEN = 8;
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = 8'b11010011;
  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v,
    input logic              en
  );
    return (en && v != '1) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/frame_deser.sv
// frame_deser: payload shift register and parallel word output.
// The last payload bit goes straight into DOUT, so history is PAY_W-1 deep.
module frame_deser
  import frame_sync_pkg::*;
#(
  parameter int PAY_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             shift_en,
  input  logic             word_last,
  input  logic             deliver_en,
  output logic [PAY_W-1:0] dout,
  output logic             dvalid
);

  logic [PAY_W-2:0] sr_q, sr_d;
  logic [PAY_W-1:0] dout_q, dout_d;
  logic [PAY_W-1:0] word;
  logic             dvalid_q, dvalid_d;

  assign word = {sr_q, din};

  always_comb begin
    sr_d     = sr_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    if (shift_en) begin
      sr_d = word[PAY_W-2:0];
    end
    if (shift_en && word_last && deliver_en) begin
      dout_d   = word;
      dvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;

endmodule

// File: rtl/frame_sync.sv
// frame_sync: hunt/check/lock frame aligner with payload deserializer.
// Define FRAME_SYNC_STATS_EN to build the FRAME_CNT/ERR_CNT counters.
module frame_sync
  import frame_sync_pkg::*;
#(
  parameter int PAY_W  = 16,
  parameter int LOCK_N = 3,
  parameter int MISS_N = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DIN,
  input  logic              SYNC_IN,
  output logic              LOCKED,
  output logic [PAY_W-1:0]  DOUT,
  output logic              DVALID,
  output logic              FRAME_ERR,
  output logic [STAT_W-1:0] FRAME_CNT,
  output logic [STAT_W-1:0] ERR_CNT
);

  localparam int FRAME_LEN = SYNC_LEN + PAY_W;
  localparam int BW = $clog2(FRAME_LEN);
  localparam int HW = $clog2(LOCK_N + 1);
  localparam int MW = $clog2(MISS_N + 1);

  localparam logic [BW-1:0] BCNT_LAST = BW'(FRAME_LEN - 1);
  localparam logic [BW-1:0] BCNT_WORD = BW'(PAY_W - 1);
  localparam logic [BW-1:0] BCNT_PAY  = BW'(PAY_W);
  localparam logic [HW-1:0] HIT_TGT   = HW'(LOCK_N);
  localparam logic [MW-1:0] MISS_TGT  = MW'(MISS_N);

  state_e        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d, bcnt_inc;
  logic [HW-1:0] hit_q, hit_d;
  logic [MW-1:0] miss_q, miss_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          slot;
  logic          shift_en, word_last, deliver_en;

  assign slot     = (bcnt_q == '0);
  assign bcnt_inc = (bcnt_q == BCNT_LAST) ? '0 : bcnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_inc;
    hit_d      = hit_q;
    miss_d     = miss_q;
    err_d      = 1'b0;
    shift_en   = (bcnt_q < BCNT_PAY);
    word_last  = (bcnt_q == BCNT_WORD);
    deliver_en = (state_q == LOCK);
    unique case (state_q)
      HUNT: begin
        // SYNC_IN marks payload bit 0: this cycle becomes BCNT 0
        bcnt_d    = '0;
        shift_en  = SYNC_IN;
        word_last = 1'b0;
        if (SYNC_IN) begin
          bcnt_d  = BW'(1);
          hit_d   = HW'(1);
          miss_d  = '0;
          state_d = (LOCK_N == 1) ? LOCK : CHECK;
        end
      end
      CHECK: begin
        if (slot && SYNC_IN) begin
          hit_d = hit_q + 1'b1;
          if (hit_q + 1'b1 == HIT_TGT) begin
            state_d = LOCK;
            miss_d  = '0;
          end
        end else if (slot) begin
          err_d   = 1'b1;
          state_d = HUNT;
          bcnt_d  = '0;
        end
      end
      LOCK: begin
        if (slot && SYNC_IN) begin
          miss_d = '0;
        end else if (slot) begin
          err_d  = 1'b1;
          miss_d = miss_q + 1'b1;
          if (miss_q + 1'b1 == MISS_TGT) begin
            state_d = HUNT;
            bcnt_d  = '0;
          end
        end
      end
      default: begin
        state_d = HUNT;
        bcnt_d  = '0;
      end
    endcase
    locked_d = (state_d == LOCK);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= HUNT;
      bcnt_q   <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  frame_deser #(
    .PAY_W(PAY_W)
  ) u_deser (
    .clk       (CLK),
    .rst       (RST),
    .din       (DIN),
    .shift_en  (shift_en),
    .word_last (word_last),
    .deliver_en(deliver_en),
    .dout      (DOUT),
    .dvalid    (DVALID)
  );

  assign LOCKED    = locked_q;
  assign FRAME_ERR = err_q;

`ifdef FRAME_SYNC_STATS_EN
  logic [STAT_W-1:0] fcnt_q, fcnt_d;
  logic [STAT_W-1:0] ecnt_q, ecnt_d;

  always_comb begin
    fcnt_d = sat_inc(fcnt_q, DVALID);
    ecnt_d = sat_inc(ecnt_q, FRAME_ERR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      ecnt_q <= ecnt_d;
    end
  end

  assign FRAME_CNT = fcnt_q;
  assign ERR_CNT   = ecnt_q;
`else
  assign FRAME_CNT = '0;
  assign ERR_CNT   = '0;
`endif

endmodule

// File: doc/frame_sync.md
Name: frame_sync

Overview:
- Downstream consumer of the serial sync-pattern detector.
- Takes the raw serial bit stream plus the detector's one-cycle match flag, and establishes frame alignment with a hunt/check/lock state machine.
- Flywheels through missing syncs and deserializes each frame's payload into parallel words for the next stage.
- Frame = 8 sync bits (pattern 11010011, MSB first) followed by PAY_W payload bits; FRAME_LEN = 8 + PAY_W.

Parameters:
PAY_W, 16, payload bits per frame; also the DOUT width; range 8..64.
LOCK_N, 3, consecutive correctly spaced syncs needed to declare lock; minimum 1.
MISS_N, 2, consecutive missed sync slots that drop lock; minimum 1.

Ports:
CLK  in  1  clock; all logic on rising edge.
RST  in  1  reset, synchronous, active-high.
DIN  in  1  serial data bit, the same stream the detector samples.
SYNC_IN  in  1  detector match flag; high in the cycle where DIN carries payload bit 0.
LOCKED  out  1  frame alignment held.
DOUT  out  PAY_W  deserialized payload, first received bit in the MSB.
DVALID  out  1  one-cycle strobe; DOUT is valid in that cycle.
FRAME_ERR  out  1  one-cycle pulse on a missed sync slot in CHECK or LOCK.
FRAME_CNT  out  16  good frames delivered (see Optional Feature).
ERR_CNT  out  16  missed sync slots (see Optional Feature).

Behaviour:
- Reset: the state goes to HUNT. BCNT, hit_cnt, miss_cnt, the shift register, LOCKED, DOUT, DVALID, FRAME_ERR and both stat counters all clear to 0.
- RST wins over every other event. RST asserted mid-frame discards the partial word and suppresses DVALID.
- BCNT counts 0..FRAME_LEN-1 and wraps to 0.
  - BCNT 0..PAY_W-1 are payload bit positions; DIN is shifted into the shift register on these.
  - BCNT PAY_W..FRAME_LEN-1 are sync bit positions.
  - BCNT==0 is the "sync slot", where SYNC_IN is expected high.
- HUNT: BCNT is ignored.
  - SYNC_IN=1: treat the current cycle as BCNT=0, shift in DIN, set BCNT<=1 and hit_cnt<=1.
  - Next state is CHECK, or LOCK directly if LOCK_N==1.
- CHECK, at the sync slot:
  - SYNC_IN=1: hit_cnt+1. When this reaches LOCK_N, go to LOCK and set miss_cnt<=0.
  - SYNC_IN=0: pulse FRAME_ERR and return to HUNT.
  - A return to HUNT does not re-evaluate the current SYNC_IN.
- LOCK, at the sync slot:
  - SYNC_IN=1: miss_cnt<=0.
  - SYNC_IN=0: pulse FRAME_ERR and miss_cnt+1. When this reaches MISS_N, go to HUNT.
  - On a miss below MISS_N (flywheel), BCNT keeps counting and payload is still delivered.
- SYNC_IN outside the sync slot in CHECK or LOCK (e.g. detector overlap or a false match in payload) is ignored: no realignment, no error.
- LOCKED is registered and equals (state==LOCK). It rises the cycle after the locking slot and falls the cycle after the final miss slot.
- Word completion: the cycle that samples BCNT==PAY_W-1 completes the word.
  - The cycle after, DOUT = the full word and DVALID = 1, but only if the state was LOCK when the word completed.
  - DOUT holds its value between strobes.
- Latency: last payload bit on DIN to DVALID is 1 cycle.
- FRAME_ERR is coincident with the cycle after the missed slot.

Optional Feature:
- Macro FRAME_SYNC_STATS_EN.
- Defined:
  - FRAME_CNT increments on each DVALID.
  - ERR_CNT increments on each FRAME_ERR.
  - Both saturate at 16'hFFFF and clear on RST.
- Undefined: both ports remain present and are tied to 16'h0000; no counter logic is generated.

Decomposition:
- Package frame_sync_pkg holds:
  - the state typedef (HUNT, CHECK, LOCK) as a 2-bit encoding;
  - SYNC_LEN=8 and SYNC_PAT=8'b11010011;
  - the stat counter width of 16.
- One sub-module, frame_deser: the PAY_W shift register, word-complete detect, and DOUT/DVALID registers. It is driven by shift-enable, BCNT==PAY_W-1 and a deliver-enable from the FSM.
- The FSM, BCNT, hit/miss counters and stats stay in frame_sync.

Test Plan (PAY_W=16, FRAME_LEN=24, LOCK_N=3, MISS_N=2; the bench drives DIN and SYNC_IN with correct relative timing):
1. Three frames, sync 0xD3 + payload 0xA55A, 24-cycle spacing -> LOCKED=1 the cycle after the 3rd SYNC_IN; no DVALID for frames 1-2; DOUT=0xA55A with DVALID the cycle after frame 3's 16th payload bit.
2. Locked; one sync slot with SYNC_IN=0, next slot good -> one FRAME_ERR pulse, LOCKED stays 1, both payloads (0x1234, 0xBEEF) delivered.
3. Locked; two consecutive slots missed -> FRAME_ERR twice, LOCKED falls the cycle after the 2nd miss; a 3rd frame's payload gives no DVALID.
4. Locked; extra SYNC_IN at BCNT=5 -> ignored; DOUT=0xA55A still delivered on schedule; no FRAME_ERR.
5. RST asserted at BCNT=9 while locked -> next cycle LOCKED=0, no DVALID for that frame; re-lock needs 3 good frames.
6. With FRAME_SYNC_STATS_EN, 4 delivered frames + 1 miss -> FRAME_CNT=4, ERR_CNT=1; without the macro both read 0.
